// File: rtl/ysyx_22040088_lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, access-size
// encodings and the alignment rule used to reject misaligned accesses.
package ysyx_22040088_lsu_pkg;

    localparam int LSU_XLEN   = 64;
    localparam int LSU_MASK_W = LSU_XLEN / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_t;

    // Natural alignment: the offset within the dword must be a multiple of the access size.
    function automatic logic is_misaligned(input size_t size, input logic [2:0] off);
        logic mis;
        mis = 1'b0;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = off[0];
            SZ_W:    mis = |off[1:0];
            default: mis = |off;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ysyx_22040088_lsu_align.sv
// Combinational lane steering: store data/strobe placement into the aligned dword
// and extraction plus sign/zero extension of load data.
module ysyx_22040088_lsu_align
    import ysyx_22040088_lsu_pkg::*;
#(
    parameter int XLEN   = LSU_XLEN,
    parameter int MASK_W = LSU_MASK_W
) (
    input  logic [2:0]        off,
    input  size_t             size,
    input  logic              is_unsigned,
    input  logic              wen,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rdata,
    output logic [XLEN-1:0]   lane_wdata,
    output logic [MASK_W-1:0] lane_wmask,
    output logic [XLEN-1:0]   load_data
);

    logic [MASK_W-1:0] base_mask;
    logic [XLEN-1:0]   shifted;

    assign lane_wdata = wdata << {off, 3'b000};
    assign shifted    = rdata >> {off, 3'b000};

    always_comb begin
        base_mask = '0;
        case (size)
            SZ_B:    base_mask = MASK_W'(8'h01);
            SZ_H:    base_mask = MASK_W'(8'h03);
            SZ_W:    base_mask = MASK_W'(8'h0F);
            default: base_mask = '1;
        endcase
        lane_wmask = wen ? (base_mask << off) : '0;
    end

    always_comb begin
        load_data = shifted;
        case (size)
            SZ_B: load_data = is_unsigned ? {{(XLEN-8){1'b0}},  shifted[7:0]}
                                          : {{(XLEN-8){shifted[7]}},   shifted[7:0]};
            SZ_H: load_data = is_unsigned ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                          : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            SZ_W: load_data = is_unsigned ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                                          : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_22040088_lsu.sv
// Load/store unit: accepts one memory op from EXU, issues a single aligned dword
// request, waits for the response and hands extended data to writeback.
module ysyx_22040088_lsu
    import ysyx_22040088_lsu_pkg::*;
#(
    parameter int XLEN   = LSU_XLEN,
    parameter int MASK_W = LSU_MASK_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic              in_wen,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_req_addr,
    output logic              mem_req_wen,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [MASK_W-1:0] mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_resp_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_rdata,
    output logic              out_misalign
);

    state_t          state;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic            wen_q;
    size_t           size_q;
    logic            unsigned_q;
    logic [XLEN-1:0] load_data;

    // Captured op registers feed the request outputs directly, so they stay stable until accepted.
    assign mem_req_addr = {addr_q[XLEN-1:3], 3'b000};
    assign mem_req_wen  = wen_q;

    ysyx_22040088_lsu_align #(.XLEN(XLEN), .MASK_W(MASK_W)) u_align (
        .off         (addr_q[2:0]),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .wen         (wen_q),
        .wdata       (wdata_q),
        .rdata       (mem_resp_rdata),
        .lane_wdata  (mem_req_wdata),
        .lane_wmask  (mem_req_wmask),
        .load_data   (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            in_ready      <= 1'b1;
            mem_req_valid <= 1'b0;
            out_valid     <= 1'b0;
            out_rdata     <= '0;
            out_misalign  <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wen_q         <= 1'b0;
            size_q        <= SZ_B;
            unsigned_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        addr_q     <= in_addr;
                        wdata_q    <= in_wdata;
                        wen_q      <= in_wen;
                        size_q     <= size_t'(in_size);
                        unsigned_q <= in_unsigned;
                        in_ready   <= 1'b0;
                        if (is_misaligned(size_t'(in_size), in_addr[2:0])) begin
                            state        <= ST_DONE;
                            out_valid    <= 1'b1;
                            out_misalign <= 1'b1;
                            out_rdata    <= '0;
                        end else begin
                            state         <= ST_REQ;
                            mem_req_valid <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        state         <= ST_WAIT;
                        mem_req_valid <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        state        <= ST_DONE;
                        out_valid    <= 1'b1;
                        out_misalign <= 1'b0;
                        out_rdata    <= wen_q ? '0 : load_data;
                    end
                end
                default: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040088_lsu.sv
// Bench for the load/store unit: random and directed ops against a byte-level
// reference of placement, strobes, extension, misalignment and handshakes.
module tb_ysyx_22040088_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_addr;
    logic [63:0] in_wdata;
    logic        in_wen;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_req_wen;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_rdata;
    logic        out_misalign;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    ysyx_22040088_lsu #(.XLEN(64), .MASK_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_addr        (in_addr),
        .in_wdata       (in_wdata),
        .in_wen         (in_wen),
        .in_size        (in_size),
        .in_unsigned    (in_unsigned),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wen    (mem_req_wen),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_rdata      (out_rdata),
        .out_misalign   (out_misalign)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    // Reference: gather the accessed bytes one at a time, then extend from the top byte.
    function automatic logic [63:0] ref_load(input logic [63:0] resp, input int off, input int nbytes,
                                             input logic uns);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < nbytes; i++) v[8*i +: 8] = resp[8*(off+i) +: 8];
        if (!uns && v[8*nbytes-1])
            for (int i = nbytes; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [7:0] ref_mask(input int off, input int nbytes);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < nbytes; i++) m[off+i] = 1'b1;
        return m;
    endfunction

    task automatic do_op(input logic [63:0] a, input logic [63:0] wd, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [63:0] resp, input int req_dly, input int out_dly,
                         output logic [63:0] o_rdata, output logic [63:0] o_addr,
                         output logic [63:0] o_wdata, output logic [7:0] o_wmask);
        int          nbytes;
        int          off;
        logic        mis;
        logic [63:0] e_rdata;
        nbytes  = 1 << sz;
        off     = int'(a[2:0]);
        mis     = (off % nbytes) != 0;
        e_rdata = '0;
        o_addr  = '0;
        o_wdata = '0;
        o_wmask = '0;
        check("idle_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_addr = a; in_wdata = wd; in_wen = we; in_size = sz; in_unsigned = uns;
        @(negedge clk);
        in_valid = 1'b0; in_addr = {$urandom, $urandom}; in_wdata = {$urandom, $urandom};
        in_wen = ~we; in_size = ~sz; in_unsigned = ~uns;
        if (mis) begin
            check("mis_no_req", 64'(mem_req_valid), 64'd0);
        end else begin
            for (int c = 0; c <= req_dly; c++) begin
                check("req_valid", 64'(mem_req_valid), 64'd1);
                check("req_addr", mem_req_addr, a & ~64'h7);
                check("req_wen", 64'(mem_req_wen), 64'(we));
                check("req_wmask", 64'(mem_req_wmask), we ? 64'(ref_mask(off, nbytes)) : 64'd0);
                check("req_wdata", mem_req_wdata, wd << (8*off));
                check("req_in_ready", 64'(in_ready), 64'd0);
                check("req_out_valid", 64'(out_valid), 64'd0);
                if (c == 0) begin o_addr = mem_req_addr; o_wdata = mem_req_wdata; o_wmask = mem_req_wmask; end
                mem_req_ready  = (c == req_dly);
                mem_resp_valid = (c != req_dly);
                mem_resp_rdata = {$urandom, $urandom};
                @(negedge clk);
            end
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            check("wait_req_low", 64'(mem_req_valid), 64'd0);
            check("wait_out_low", 64'(out_valid), 64'd0);
            mem_resp_valid = 1'b1; mem_resp_rdata = resp;
            @(negedge clk);
            mem_resp_valid = 1'b0; mem_resp_rdata = {$urandom, $urandom};
            e_rdata = we ? 64'd0 : ref_load(resp, off, nbytes, uns);
        end
        o_rdata = out_rdata;
        for (int c = 0; c <= out_dly; c++) begin
            check("done_out_valid", 64'(out_valid), 64'd1);
            check("done_out_rdata", out_rdata, e_rdata);
            check("done_misalign", 64'(out_misalign), 64'(mis));
            check("done_in_ready", 64'(in_ready), 64'd0);
            check("done_req_low", 64'(mem_req_valid), 64'd0);
            out_ready      = (c == out_dly);
            mem_resp_valid = 1'b1;
            mem_resp_rdata = {$urandom, $urandom};
            @(negedge clk);
        end
        out_ready = 1'b0; mem_resp_valid = 1'b0;
        check("back_out_valid", 64'(out_valid), 64'd0);
        check("back_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] r, ad, wdv;
        logic [7:0]  m;
        logic        we;
        logic [1:0]  sz;
        rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_wdata = '0; in_wen = 1'b0; in_size = '0;
        in_unsigned = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        out_ready = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_req_addr", mem_req_addr, 64'd0);
        check("rst_req_wmask", 64'(mem_req_wmask), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_rdata", out_rdata, 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases with literal expectations.
        do_op(64'h8000_0004, 64'h1122_3344, 1'b1, 2'b10, 1'b0, 64'd0, 0, 0, r, ad, wdv, m);
        check("sw_addr", ad, 64'h8000_0000);
        check("sw_wmask", 64'(m), 64'hF0);
        check("sw_wdata", wdv, 64'h1122_3344_0000_0000);
        check("sw_rdata", r, 64'd0);
        do_op(64'h8000_0003, 64'd0, 1'b0, 2'b00, 1'b0, 64'h0000_0000_80FF_0000, 0, 0, r, ad, wdv, m);
        check("lb_rdata", r, 64'hFFFF_FFFF_FFFF_FF80);
        do_op(64'h8000_0006, 64'd0, 1'b0, 2'b01, 1'b1, 64'hBEEF_0000_0000_0000, 0, 0, r, ad, wdv, m);
        check("lhu_rdata", r, 64'h0000_0000_0000_BEEF);
        do_op(64'h8000_0004, 64'd0, 1'b0, 2'b11, 1'b0, 64'd0, 0, 0, r, ad, wdv, m);
        check("ld_mis_rdata", r, 64'd0);
        do_op(64'h8000_0010, 64'hA5A5_5A5A_0F0F_F0F0, 1'b1, 2'b11, 1'b0, 64'd0, 3, 2, r, ad, wdv, m);
        check("sd_stall_wmask", 64'(m), 64'hFF);

        // Randomized ops with stalls.
        for (int k = 0; k < 40; k++) begin
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            do_op({32'h8000_0000, $urandom}, {$urandom, $urandom}, we, sz, 1'($urandom_range(0, 1)),
                  {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 2), r, ad, wdv, m);
        end

        // Reset while waiting for the response; the late response must be ignored.
        in_valid = 1'b1; in_addr = 64'h8000_0008; in_wen = 1'b0; in_size = 2'b11; in_unsigned = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("pre_rst_wait", 64'(mem_req_valid), 64'd0);
        rst = 1'b1;
        #1;
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_req_valid", 64'(mem_req_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_resp_valid = 1'b1; mem_resp_rdata = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        check("late_resp_out_valid", 64'(out_valid), 64'd0);
        check("late_resp_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        check("late_resp_out_valid2", 64'(out_valid), 64'd0);
        do_op(64'h8000_0020, 64'd0, 1'b0, 2'b10, 1'b1, 64'h0000_0000_FFFF_FFFF, 1, 1, r, ad, wdv, m);
        check("recover_lwu", r, 64'h0000_0000_FFFF_FFFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
